score_bcd_display: RTL and testbench
====================================

SCORE_BCD_DISPLAY -- requirements
Module: score_bcd_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, giving clk cycles per digit scan slot; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1, system clock.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port score, input, 8, unsigned game score from the game FSM.
REQ-005 The block SHALL have port score_valid, input, 1, single-cycle strobe marking a new score value.
REQ-006 The block SHALL have port game_end, input, 1, level that is high while the game is over.
REQ-007 The block SHALL have port show_high, input, 1, level (debounced) selecting high-score display.
REQ-008 The block SHALL have port seg, output, 7, active-low segments a..g on bits 0..6.
REQ-009 The block SHALL have port dp, output, 1, active-low decimal point.
REQ-010 The block SHALL have port digit_en, output, 3, active-low digit enables: bit0 units, bit1 tens, bit2 hundreds.
REQ-011 The block SHALL have port high_score, output, 8, best score since reset.
REQ-012 The block SHALL have port busy, output, 1, high while a BCD conversion is in progress.

Function
REQ-013 On score_valid, the block SHALL capture score into score_reg at that clock edge, regardless of busy.
REQ-014 On a game_end rising edge, the block SHALL write high_score from the compare operand if that operand is strictly greater than high_score; equal scores leave it unchanged.
- Compare operand: the score input if score_valid is high in the same cycle, else score_reg.
REQ-015 A conversion request flag SHALL be set by each of: score_valid, any show_high change, any high_score update.
- Multiple requests while busy SHALL collapse into one pending request.
REQ-016 The converter FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE with request set: sample operand (show_high ? high_score : score_reg), clear request, go to SHIFT.
- SHIFT: one double-dabble iteration per cycle for exactly 8 cycles, then go to DONE.
- DONE: write the 12-bit BCD result into the display register, go to IDLE.
REQ-017 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-018 With the converter idle, a score_valid at cycle T SHALL make the display register hold the new value from cycle T+11 onward.
REQ-019 A request arriving during SHIFT or DONE SHALL be served on the first IDLE cycle after the current conversion, using operand values from that cycle.
REQ-020 The scan prescaler SHALL count 0..SCAN_DIV-1; at the terminal count, the digit index SHALL advance 0->1->2->0. With SCAN_DIV=1 it advances every cycle.
REQ-021 Exactly one digit_en bit SHALL be low at any time, namely the bit for the current digit index.
REQ-022 Blanking SHALL follow these rules, where blank means seg=7'h7F:
- Hundreds is blank if it is 0.
- Tens is blank if both hundreds and tens are 0.
- Units is never blank.
REQ-023 Segment patterns SHALL be standard active-low hex glyphs (0=7'h40, 1=7'h79, ..., 9=7'h10).
REQ-024 dp SHALL be 0 only while the units digit is selected and show_high=1; otherwise dp SHALL be 1.
REQ-025 seg, dp and digit_en SHALL be registered outputs, with one cycle latency from the digit index and display register.

Reset
REQ-026 Reset SHALL set all state as follows:
- score_reg=0, high_score=0, display register=0, request=0.
- FSM=IDLE, busy=0, prescaler=0, digit index=0.
- seg=7'h40 ("0"), dp=1, digit_en=3'b110.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no partial write; the display SHALL show "0".

Structure
REQ-028 A shared package whack_pkg SHALL hold the converter state enum, the 7-segment glyph constants, SEG_BLANK, and NUM_DIGITS=3.
REQ-029 The double-dabble datapath and FSM SHALL be a sub-module named bin2bcd_seq.
- Ports: clk, rst_n, start, bin[7:0], busy, done, bcd[11:0].

Verification
REQ-030 score=8'd0 with score_valid, SCAN_DIV=1 -> only units is lit with 7'h40; tens and hundreds slots show 7'h7F.
REQ-031 score=8'd255 with score_valid at cycle T -> busy high T+2..T+10; display "2","5","5" from T+11.
REQ-032 score=8'd7 with score_valid, then score=8'd42 with score_valid 3 cycles later -> second conversion follows the first; final display "42" with the hundreds slot blank.
REQ-033 score=8'd105, game_end rising edge -> high_score=105; then score=8'd105 with game_end rising again -> high_score stays 105; score=8'd99 -> stays 105.
REQ-034 high_score=105, score_reg=12, show_high toggled 0->1 -> display "105" with dp=0 on units; toggled back -> "12", dp=1.
REQ-035 rst_n asserted during SHIFT of score=8'd200 -> all outputs at their reset values immediately; after release, display "0" and busy=0.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and constants for the score display slice: converter
// state encoding, active-low 7-segment glyphs and the digit count.
package whack_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Map a nibble to its active-low hex glyph (a..g on bits 0..6).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble),
// one shift-and-adjust iteration per clock, eight iterations per value.
module bin2bcd_seq
    import whack_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;

    // One double-dabble step: bump every BCD nibble >= 5 by 3, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] adj;
        adj = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {adj[18:0], 1'b0};
    endfunction

    // Converter state, working shift register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: load on start, iterate eight times, then present result.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {12'd0, bin};
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = dabble_step(shift_q);
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = shift_q[19:8];

endmodule

// File: rtl/score_bcd_display.sv
// Score display controller: latches the game score, tracks the best score,
// converts the selected value to BCD and multiplexes it onto three
// active-low 7-segment digits with leading-zero blanking.
module score_bcd_display
    import whack_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score,
    input  logic       score_valid,
    input  logic       game_end,
    input  logic       show_high,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit_en,
    output logic [7:0] high_score,
    output logic       busy
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [1:0]  DIGIT_LAST = 2'(NUM_DIGITS - 1);

    logic [7:0]  score_reg_q, score_reg_d;
    logic [7:0]  high_score_q, high_score_d;
    logic [11:0] display_q, display_d;
    logic        request_q, request_d;
    logic        game_end_prev_q;
    logic        show_high_prev_q;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  digit_idx_q, digit_idx_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [2:0]  digit_en_q, digit_en_d;

    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    logic [7:0]  conv_operand;
    logic [11:0] conv_bcd;
    logic [7:0]  compare_operand;
    logic        high_update;
    logic        request_set;

    assign conv_start      = request_q && !conv_busy;
    assign conv_operand    = show_high ? high_score_q : score_reg_q;
    assign compare_operand = score_valid ? score : score_reg_q;
    assign high_update     = game_end && !game_end_prev_q
                             && (compare_operand > high_score_q);
    assign request_set     = score_valid || (show_high != show_high_prev_q)
                             || high_update;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_operand),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // All controller state, including the registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_reg_q      <= '0;
            high_score_q     <= '0;
            display_q        <= '0;
            request_q        <= 1'b0;
            game_end_prev_q  <= 1'b0;
            show_high_prev_q <= 1'b0;
            presc_q          <= '0;
            digit_idx_q      <= '0;
            seg_q            <= SEG_0;
            dp_q             <= 1'b1;
            digit_en_q       <= 3'b110;
        end else begin
            score_reg_q      <= score_reg_d;
            high_score_q     <= high_score_d;
            display_q        <= display_d;
            request_q        <= request_d;
            game_end_prev_q  <= game_end;
            show_high_prev_q <= show_high;
            presc_q          <= presc_d;
            digit_idx_q      <= digit_idx_d;
            seg_q            <= seg_d;
            dp_q             <= dp_d;
            digit_en_q       <= digit_en_d;
        end
    end

    // Score capture, best-score update, request collapsing and result write-back;
    // a new request in the same cycle the old one is consumed stays pending.
    always_comb begin
        score_reg_d  = score_valid ? score : score_reg_q;
        high_score_d = high_update ? compare_operand : high_score_q;
        display_d    = conv_done ? conv_bcd : display_q;
        request_d    = request_q;
        if (conv_start) begin
            request_d = 1'b0;
        end
        if (request_set) begin
            request_d = 1'b1;
        end
    end

    // Scan prescaler and digit index rotation units -> tens -> hundreds.
    always_comb begin
        presc_d     = presc_q + 16'd1;
        digit_idx_d = digit_idx_q;
        if (presc_q >= SCAN_LAST) begin
            presc_d     = '0;
            digit_idx_d = (digit_idx_q >= DIGIT_LAST) ? 2'd0 : digit_idx_q + 2'd1;
        end
    end

    // Glyph, decimal point and enable for the selected digit, with leading-zero blanking.
    always_comb begin
        seg_d      = hex_to_seg(display_q[3:0]);
        dp_d       = 1'b1;
        digit_en_d = 3'b110;
        case (digit_idx_q)
            2'd1: begin
                digit_en_d = 3'b101;
                seg_d      = (display_q[11:4] == 8'd0) ? SEG_BLANK
                                                       : hex_to_seg(display_q[7:4]);
            end
            2'd2: begin
                digit_en_d = 3'b011;
                seg_d      = (display_q[11:8] == 4'd0) ? SEG_BLANK
                                                       : hex_to_seg(display_q[11:8]);
            end
            default: begin
                digit_en_d = 3'b110;
                seg_d      = hex_to_seg(display_q[3:0]);
                dp_d       = !show_high;
            end
        endcase
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_en   = digit_en_q;
    assign high_score = high_score_q;
    assign busy       = conv_busy;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed testbench for score_bcd_display with a one-cycle scan slot.
module tb_score_bcd_display;

    logic       clk;
    logic       rst_n;
    logic [7:0] score;
    logic       score_valid;
    logic       game_end;
    logic       show_high;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] digit_en;
    logic [7:0] high_score;
    logic       busy;

    int total;
    int bad;

    score_bcd_display #(.SCAN_DIV(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score       (score),
        .score_valid (score_valid),
        .game_end    (game_end),
        .show_high   (show_high),
        .seg         (seg),
        .dp          (dp),
        .digit_en    (digit_en),
        .high_score  (high_score),
        .busy        (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (14) tick();
    endtask

    task automatic pulse_score(input logic [7:0] value);
        score       = value;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    // Capture one full scan: glyph per digit slot and dp on the units slot.
    task automatic read_digits(output logic [6:0] u, output logic [6:0] t,
                               output logic [6:0] h, output logic du, output logic dt);
        u = 7'hxx; t = 7'hxx; h = 7'hxx; du = 1'bx; dt = 1'bx;
        for (int i = 0; i < 3; i++) begin
            tick();
            case (digit_en)
                3'b110: begin u = seg; du = dp; end
                3'b101: begin t = seg; dt = dp; end
                3'b011: h = seg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; score = '0; score_valid = 0; game_end = 0; show_high = 0;
        repeat (2) tick();
        total++; if (seg !== 7'h40) begin bad++; $display("[TB] FAIL reset_seg: got %h expected 40", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
        total++; if (digit_en !== 3'b110) begin bad++; $display("[TB] FAIL reset_digit_en: got %b expected 110", digit_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (high_score !== 8'd0) begin bad++; $display("[TB] FAIL reset_high: got %0d expected 0", high_score); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        logic [6:0] u, t, h;
        logic du, dt;
        pulse_score(8'd0);
        settle();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (digit_en !== 3'b110 && digit_en !== 3'b101 && digit_en !== 3'b011) begin
                bad++; $display("[TB] FAIL enable_onehot: got %b expected one low bit", digit_en);
            end
        end
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h40) begin bad++; $display("[TB] FAIL zero_units: got %h expected 40", u); end
        total++; if (t !== 7'h7F) begin bad++; $display("[TB] FAIL zero_tens: got %h expected 7f", t); end
        total++; if (h !== 7'h7F) begin bad++; $display("[TB] FAIL zero_hundreds: got %h expected 7f", h); end
        total++; if (du !== 1'b1) begin bad++; $display("[TB] FAIL zero_dp: got %b expected 1", du); end
    endtask

    task automatic test_255_timing();
        logic [6:0] u, t, h;
        logic du, dt;
        pulse_score(8'd255);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_T1: got %b expected 0", busy); end
        for (int k = 2; k <= 11; k++) begin
            tick();
            total++;
            if (busy !== (k <= 10)) begin
                bad++; $display("[TB] FAIL busy_T%0d: got %b expected %b", k, busy, (k <= 10));
            end
        end
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h12) begin bad++; $display("[TB] FAIL 255_units: got %h expected 12", u); end
        total++; if (t !== 7'h12) begin bad++; $display("[TB] FAIL 255_tens: got %h expected 12", t); end
        total++; if (h !== 7'h24) begin bad++; $display("[TB] FAIL 255_hundreds: got %h expected 24", h); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] u, t, h;
        logic du, dt;
        settle();
        pulse_score(8'd7);
        tick();
        tick();
        pulse_score(8'd42);
        repeat (7) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap: got %b expected 0", busy); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_start: got %b expected 1", busy); end
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h78) begin bad++; $display("[TB] FAIL b2b_first_units: got %h expected 78", u); end
        total++; if (t !== 7'h7F) begin bad++; $display("[TB] FAIL b2b_first_tens: got %h expected 7f", t); end
        settle();
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h24) begin bad++; $display("[TB] FAIL b2b_units: got %h expected 24", u); end
        total++; if (t !== 7'h19) begin bad++; $display("[TB] FAIL b2b_tens: got %h expected 19", t); end
        total++; if (h !== 7'h7F) begin bad++; $display("[TB] FAIL b2b_hundreds: got %h expected 7f", h); end
    endtask

    task automatic test_high_score();
        score = 8'd105; score_valid = 1'b1; game_end = 1'b1;
        tick();
        score_valid = 1'b0;
        total++; if (high_score !== 8'd105) begin bad++; $display("[TB] FAIL high_first: got %0d expected 105", high_score); end
        game_end = 1'b0; tick();
        score = 8'd105; score_valid = 1'b1; game_end = 1'b1;
        tick();
        score_valid = 1'b0;
        total++; if (high_score !== 8'd105) begin bad++; $display("[TB] FAIL high_equal: got %0d expected 105", high_score); end
        game_end = 1'b0; tick();
        score = 8'd99; score_valid = 1'b1; game_end = 1'b1;
        tick();
        score_valid = 1'b0;
        total++; if (high_score !== 8'd105) begin bad++; $display("[TB] FAIL high_lower: got %0d expected 105", high_score); end
        game_end = 1'b0;
        settle();
    endtask

    task automatic test_show_high();
        logic [6:0] u, t, h;
        logic du, dt;
        pulse_score(8'd12);
        settle();
        show_high = 1'b1;
        settle();
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h12) begin bad++; $display("[TB] FAIL high_units: got %h expected 12", u); end
        total++; if (t !== 7'h40) begin bad++; $display("[TB] FAIL high_tens: got %h expected 40", t); end
        total++; if (h !== 7'h79) begin bad++; $display("[TB] FAIL high_hundreds: got %h expected 79", h); end
        total++; if (du !== 1'b0) begin bad++; $display("[TB] FAIL high_dp_units: got %b expected 0", du); end
        total++; if (dt !== 1'b1) begin bad++; $display("[TB] FAIL high_dp_tens: got %b expected 1", dt); end
        show_high = 1'b0;
        settle();
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h24) begin bad++; $display("[TB] FAIL back_units: got %h expected 24", u); end
        total++; if (t !== 7'h79) begin bad++; $display("[TB] FAIL back_tens: got %h expected 79", t); end
        total++; if (h !== 7'h7F) begin bad++; $display("[TB] FAIL back_hundreds: got %h expected 7f", h); end
        total++; if (du !== 1'b1) begin bad++; $display("[TB] FAIL back_dp: got %b expected 1", du); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] u, t, h;
        logic du, dt;
        pulse_score(8'd200);
        repeat (3) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (seg !== 7'h40) begin bad++; $display("[TB] FAIL mid_seg: got %h expected 40", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL mid_dp: got %b expected 1", dp); end
        total++; if (digit_en !== 3'b110) begin bad++; $display("[TB] FAIL mid_digit_en: got %b expected 110", digit_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        total++; if (high_score !== 8'd0) begin bad++; $display("[TB] FAIL mid_high: got %0d expected 0", high_score); end
        tick();
        rst_n = 1'b1;
        settle();
        read_digits(u, t, h, du, dt);
        total++; if (u !== 7'h40) begin bad++; $display("[TB] FAIL post_units: got %h expected 40", u); end
        total++; if (t !== 7'h7F) begin bad++; $display("[TB] FAIL post_tens: got %h expected 7f", t); end
        total++; if (h !== 7'h7F) begin bad++; $display("[TB] FAIL post_hundreds: got %h expected 7f", h); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL post_busy: got %b expected 0", busy); end
    endtask

    // Scenario sequence.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_255_timing();
        test_back_to_back();
        test_high_score();
        test_show_high();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
